sync_down_timer: RTL and testbench
==================================

// Module: sync_down_timer
// PURPOSE
//  Loadable synchronous down-counting timer, the count-down counterpart of our free-running up counter.
//  Takes a start value over a valid/ready load handshake and counts to zero on start.
//  Emits a one-cycle terminal-count pulse, in one-shot or auto-reload mode.
//  Used as the interval/timeout source for control FSMs elsewhere in the design.
// PARAMETERS
//  WIDTH   4   counter and load-value width in bits (legal range >= 2)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      reset, asynchronous, active-low
//  load_valid   in   1      load request; qualifies load_val
//  load_ready   out  1      block can accept a load
//  load_val     in   WIDTH  start/reload value
//  start        in   1      begin counting (one-cycle strobe)
//  pause        in   1      level; freezes the count while high
//  abort        in   1      one-cycle strobe; cancels a run
//  auto_reload  in   1      level; 1 = periodic, 0 = one-shot
//  cnt          out  WIDTH  current count
//  tc           out  1      terminal-count pulse, registered, one cycle
//  busy         out  1      state is RUN or HOLD
//  done         out  1      state is DONE (one-shot expired)
// BEHAVIOUR
//  - Reset, while rst_n=0 and immediate: state=IDLE, cnt=0, reload_reg=0, tc=0, busy=0, done=0, load_ready=1.
//  - All outputs are registered or decoded from state. No combinational path from inputs to outputs.
//  - States are IDLE, RUN, HOLD and DONE. load_ready=1 only in IDLE and DONE.
//  - Load transfer happens on the edge where load_valid&&load_ready.
//    - Next cycle: reload_reg=cnt=load_val.
//    - From DONE, a load moves to IDLE and clears done.
//  - IDLE:
//    - Load takes priority over a start in the same cycle; the start is dropped.
//    - start with cnt!=0 goes to RUN. The first decrement happens on the edge after entry.
//    - start with cnt==0 is ignored.
//  - RUN, per cycle, priority abort > pause > count:
//    - abort: go to IDLE, cnt<=reload_reg, no tc.
//    - pause=1: go to HOLD, cnt held.
//    - cnt>1: cnt<=cnt-1.
//    - cnt==1: tc<=1. Then, with auto_reload sampled this cycle:
//      - auto_reload=1 and reload_reg!=0: cnt<=reload_reg, stay in RUN. tc period = reload value in cycles.
//      - otherwise: cnt<=0, go to DONE.
//  - HOLD:
//    - abort goes to IDLE, cnt<=reload_reg.
//    - pause=0 goes to RUN. No decrement on the exit edge.
//  - DONE:
//    - start with reload_reg!=0: cnt<=reload_reg, go to RUN.
//    - A load goes to IDLE, as above.
//  - tc is high for exactly one cycle per expiry. It is high in the same cycle cnt shows 0 (one-shot) or the reload value.
//  - No underflow: cnt never decrements below 0 and never wraps to 2^WIDTH-1.
//  - Loads offered in RUN or HOLD are not accepted (load_ready=0). The requester must hold load_valid.
//  - Inputs are synchronous to clk. Latency from start to the first cnt change is 2 edges.
// STRUCTURE
//  - Shared package timer_pkg: state encodings ST_IDLE/ST_RUN/ST_HOLD/ST_DONE (2-bit) and the WIDTH default.
//  - One sub-module, dcnt_core: cnt/reload_reg datapath with controls load, dec, reload and zero-detect.
//  - The top level holds the FSM, the handshake and the tc register.
// TESTING (WIDTH=4)
//  1. Drop rst_n mid-RUN at cnt=5 -> same cycle cnt=0, busy=0, tc=0, load_ready=1. Release -> IDLE.
//  2. Load 3, auto_reload=0, start -> cnt 3,2,1,0 on consecutive cycles. tc=1 only with cnt=0, then done=1, busy=0.
//  3. Load 4, auto_reload=1, start -> cnt 4,3,2,1,4,3,... with tc every 4th cycle. Clear auto_reload -> next expiry ends in DONE.
//  4. Load 6, start, pause high 3 cycles at cnt=4 -> cnt holds 4, busy=1. Resumes 3 one cycle after pause drops.
//  5. Load 15 and start in the same cycle -> start ignored. Then start -> tc after 15 cycles, cnt stays 0, never 15.
//  6. Load 7, start, abort at cnt=2 -> IDLE, cnt=7, no tc. load_valid held during RUN is accepted only after the abort.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting timer: FSM state encoding and default width.
package timer_pkg;

    localparam int TIMER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dcnt_core.sv
// Count/reload datapath for the down timer: holds the live count and the reload value,
// and reports the zero / one / empty-reload conditions the controlling FSM decides on.
module dcnt_core
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             reload,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt,
    output logic             is_zero,
    output logic             is_one,
    output logic             reload_zero
);

    logic [WIDTH-1:0] reload_reg;

    // Count and reload registers; load beats reload beats clear beats decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            reload_reg <= '0;
        end else if (load) begin
            cnt        <= load_val;
            reload_reg <= load_val;
        end else if (reload) begin
            cnt <= reload_reg;
        end else if (clear) begin
            cnt <= '0;
        end else if (dec && !is_zero) begin
            // Guarded so the count can never wrap below zero.
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign is_zero     = (cnt == '0);
    assign is_one      = (cnt == WIDTH'(1));
    assign reload_zero = (reload_reg == '0);

endmodule

// File: rtl/sync_down_timer.sv
// Loadable down-counting timer with pause/abort, one-shot or auto-reload expiry and a
// registered one-cycle terminal-count pulse. FSM and handshake live here; the count is in dcnt_core.
module sync_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_next;

    logic load_fire;
    logic ctl_dec;
    logic ctl_reload;
    logic ctl_clear;
    logic tc_next;
    logic is_zero;
    logic is_one;
    logic reload_zero;
    logic keep_running;

    assign load_fire    = load_valid && load_ready;
    assign keep_running = auto_reload && !reload_zero;

    dcnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_fire),
        .load_val   (load_val),
        .dec        (ctl_dec),
        .reload     (ctl_reload),
        .clear      (ctl_clear),
        .cnt        (cnt),
        .is_zero    (is_zero),
        .is_one     (is_one),
        .reload_zero(reload_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state selection; abort outranks pause, which outranks counting.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                // A load in the same cycle swallows the start.
                if (!load_fire && start && !is_zero) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                       state_next = ST_IDLE;
                else if (pause)                  state_next = ST_HOLD;
                else if (is_one && !keep_running) state_next = ST_DONE;
            end
            ST_HOLD: begin
                if (abort)       state_next = ST_IDLE;
                else if (!pause) state_next = ST_RUN;
            end
            ST_DONE: begin
                if (load_fire)                    state_next = ST_IDLE;
                else if (start && !reload_zero)   state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath controls, expiry detect and state-decoded status outputs.
    always_comb begin
        ctl_dec    = 1'b0;
        ctl_reload = 1'b0;
        ctl_clear  = 1'b0;
        tc_next    = 1'b0;
        load_ready = (state == ST_IDLE) || (state == ST_DONE);
        busy       = (state == ST_RUN) || (state == ST_HOLD);
        done       = (state == ST_DONE);
        unique case (state)
            ST_RUN: begin
                if (abort) begin
                    ctl_reload = 1'b1;
                end else if (!pause) begin
                    if (is_one) begin
                        tc_next = 1'b1;
                        if (keep_running) ctl_reload = 1'b1;
                        else              ctl_clear  = 1'b1;
                    end else begin
                        ctl_dec = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Leaving HOLD does not decrement; only abort touches the count.
                if (abort) ctl_reload = 1'b1;
            end
            ST_DONE: begin
                if (!load_fire && start && !reload_zero) ctl_reload = 1'b1;
            end
            default: ;
        endcase
    end

    // Terminal-count pulse, registered so it lines up with the expiring count value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tc <= 1'b0;
        else        tc <= tc_next;
    end

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: a behavioural model predicts each cycle's outputs,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_sync_down_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         done;

    sync_down_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .auto_reload(auto_reload),
        .cnt        (cnt),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cnt;
        bit           tc;
        bit           busy;
        bit           done;
        bit           ready;
        int           tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   tag = 0;

    // Reference model: mode 0 idle, 1 counting, 2 frozen, 3 expired.
    int m_mode;
    int m_cnt;
    int m_rl;
    bit m_tc;

    function automatic void model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_rl   = 0;
        m_tc   = 0;
    endfunction

    function automatic void model_step(bit lv, int lval, bit st, bit pz, bit ab, bit ar);
        bit accepting;
        if (!rst_n) begin
            model_reset();
            return;
        end
        accepting = (m_mode == 0) || (m_mode == 3);
        m_tc = 0;
        if (lv && accepting) begin
            m_cnt  = lval;
            m_rl   = lval;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st && m_cnt != 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ab) begin
                m_mode = 0;
                m_cnt  = m_rl;
            end else if (pz) begin
                m_mode = 2;
            end else if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_tc = 1;
                if (ar && m_rl != 0) begin
                    m_cnt = m_rl;
                end else begin
                    m_cnt  = 0;
                    m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            if (ab) begin
                m_mode = 0;
                m_cnt  = m_rl;
            end else if (!pz) begin
                m_mode = 1;
            end
        end else begin
            if (st && m_rl != 0) begin
                m_cnt  = m_rl;
                m_mode = 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.cnt   = m_cnt[W-1:0];
        e.tc    = m_tc;
        e.busy  = (m_mode == 1) || (m_mode == 2);
        e.done  = (m_mode == 3);
        e.ready = (m_mode == 0) || (m_mode == 3);
        e.tag   = tag;
        return e;
    endfunction

    task automatic cycle(bit lv, int lval, bit st, bit pz, bit ab);
        load_valid = lv;
        load_val   = lval[W-1:0];
        start      = st;
        pause      = pz;
        abort      = ab;
        model_step(lv, lval, st, pz, ab, auto_reload);
        @(posedge clk);
        #1;
        q.push_back(model_out());
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cnt !== '0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset sc%0d: cnt=%0d tc=%0b busy=%0b done=%0b ready=%0b, expected cnt=0 tc=0 busy=0 done=0 ready=1",
                     tag, cnt, tc, busy, done, load_ready);
        end
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    // Monitor: every falling edge the DUT presents one cycle's outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            vectors++;
            if (cnt !== mon_e.cnt || tc !== mon_e.tc || busy !== mon_e.busy ||
                done !== mon_e.done || load_ready !== mon_e.ready) begin
                miscompares++;
                $display("FAIL vec%0d sc%0d: cnt=%0d tc=%0b busy=%0b done=%0b ready=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b ready=%0b",
                         vectors, mon_e.tag, cnt, tc, busy, done, load_ready,
                         mon_e.cnt, mon_e.tc, mon_e.busy, mon_e.done, mon_e.ready);
            end
        end
    end

    initial begin
        model_reset();
        idle(2);
        rst_n = 1'b1;

        // Reset dropped while running at cnt=5.
        tag = 1;
        cycle(1, 6, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(1);
        do_reset();

        // One-shot from 3.
        tag = 2;
        auto_reload = 1'b0;
        cycle(1, 3, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(6);

        // Auto-reload from 4, then one-shot finish.
        tag = 3;
        cycle(1, 4, 0, 0, 0);
        auto_reload = 1'b1;
        cycle(0, 0, 1, 0, 0);
        idle(10);
        auto_reload = 1'b0;
        idle(6);

        // Pause for three cycles at cnt=4.
        tag = 4;
        cycle(1, 6, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(2);
        repeat (3) cycle(0, 0, 0, 1, 0);
        idle(8);

        // Load and start together: start dropped; then full 15-cycle run.
        tag = 5;
        cycle(1, 15, 1, 0, 0);
        idle(2);
        cycle(0, 0, 1, 0, 0);
        idle(20);

        // Abort at cnt=2 with a load held during the run.
        tag = 6;
        cycle(1, 7, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (5) cycle(1, 9, 0, 0, 0);
        cycle(1, 9, 0, 0, 1);
        cycle(1, 9, 0, 0, 0);
        idle(3);

        // Randomised traffic, biased toward short intervals so expiries are frequent.
        tag = 7;
        for (int i = 0; i < 3000; i++) begin
            int lval;
            if ($urandom % 60 == 0) auto_reload = ~auto_reload;
            if ($urandom % 700 == 0) do_reset();
            lval = ($urandom % 2 == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
            cycle(($urandom % 4) == 0, lval, ($urandom % 3) == 0,
                  ($urandom % 10) == 0, ($urandom % 20) == 0);
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
